// File: rtl/morph_pkg.sv
// morph_pkg: shared types and helpers for the 3x3 morphology filter.
// Holds the operation enum, the frame FSM state enum and the neutral-value
// helper used to fill window taps that fall outside the image.
package morph_pkg;

    typedef enum logic {
        MORPH_DILATE = 1'b0,
        MORPH_ERODE  = 1'b1
    } morph_mode_e;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } morph_state_e;

    // Widest pixel the neutral helper can describe.
    localparam int MORPH_MAX_W = 64;

    // Side length of the square window.
    localparam int WIN = 3;

    // Value that never wins the compare: 0 for max, all-ones for min.
    // The caller truncates the result to its own pixel width.
    function automatic logic [MORPH_MAX_W-1:0] morph_neutral(input int data_w,
                                                             input morph_mode_e m);
        logic [MORPH_MAX_W-1:0] v;
        v = '0;
        if (m == MORPH_ERODE) begin
            for (int i = 0; i < MORPH_MAX_W; i++) begin
                if (i < data_w) begin
                    v[i] = 1'b1;
                end
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/morph_line_buf.sv
// morph_line_buf: DATA_W x IMG_W shift line. Each enabled cycle pushes one
// pixel in; the tail presents the pixel pushed IMG_W enables earlier, which
// is the pixel directly above the one currently being pushed.
// Contents are deliberately not reset; the filter masks stale pixels.
module morph_line_buf
    import morph_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 640
) (
    input  logic              clk,
    input  logic              en_i,
    input  logic [DATA_W-1:0] din_i,
    output logic [DATA_W-1:0] dout_o
);

    logic [DATA_W-1:0] line_q [IMG_W];

    // Shift the whole line by one position per enabled cycle.
    always_ff @(posedge clk) begin
        if (en_i) begin
            line_q[0] <= din_i;
            for (int i = 1; i < IMG_W; i++) begin
                line_q[i] <= line_q[i-1];
            end
        end
    end

    assign dout_o = line_q[IMG_W-1];

endmodule

// File: rtl/morph_filter_3x3.sv
// morph_filter_3x3: streaming 3x3 grayscale dilation / erosion over a
// raster frame of IMG_W x IMG_H pixels, with explicit border handling and a
// self-flush of the trailing IMG_W+1 results at end of frame.
// Optional feature macro: MORPH_MODE_EN adds the runtime 'mode' port
// (0 = dilate, 1 = erode, captured on the first pixel of each frame).
// Without it the block is dilate only and the min path is not built.
module morph_filter_3x3 #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480
) (
    input  logic              clk,
    input  logic              rst,
`ifdef MORPH_MODE_EN
    input  logic              mode,
`endif
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    import morph_pkg::*;

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);

    // Frame FSM and raster counters. The input counters track the next pixel
    // to be accepted; the output counters track the window centre, i.e. the
    // pixel whose result is produced next.
    morph_state_e  state_q, state_d;
    logic [CW-1:0] in_col_q, in_col_d;
    logic [RW-1:0] in_row_q, in_row_d;
    logic [CW-1:0] out_col_q, out_col_d;
    logic [RW-1:0] out_row_q, out_row_d;

    logic              beat;
    logic              shift_en;
    logic              produce;
    logic [DATA_W-1:0] pix_in;

    // Window storage: [row][col], row 0 = two lines up, col 2 = newest.
    logic [DATA_W-1:0] lb0_out;
    logic [DATA_W-1:0] lb1_out;
    logic [DATA_W-1:0] win_q   [WIN][WIN];
    logic [DATA_W-1:0] new_col [WIN];
    logic [DATA_W-1:0] tap     [WIN][WIN];

    logic [WIN-1:0]    row_ok;
    logic [WIN-1:0]    col_ok;
    logic [DATA_W-1:0] neutral;
    logic [DATA_W-1:0] cand;
    logic [DATA_W-1:0] result;

    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;

    assign beat = in_valid & in_ready;

    // Next state and per-cycle strobes; nothing moves without a beat except in FLUSH.
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        shift_en = 1'b0;
        produce  = 1'b0;
        pix_in   = in_data;
        case (state_q)
            FILL: begin
                in_ready = ~rst;
                if (in_valid && !rst) begin
                    shift_en = 1'b1;
                    // Pixel IMG_W sits at (row 1, col 0); after it the window
                    // is one step away from its first complete centre.
                    if (in_col_q == '0 && in_row_q == ROW_ONE) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                in_ready = ~rst;
                if (in_valid && !rst) begin
                    shift_en = 1'b1;
                    produce  = 1'b1;
                    if (in_col_q == COL_LAST && in_row_q == ROW_LAST) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                // Dummy pixel; it only ever lands in masked taps.
                pix_in   = '0;
                shift_en = 1'b1;
                produce  = 1'b1;
                if (out_col_q == COL_LAST && out_row_q == ROW_LAST) begin
                    state_d = FILL;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // Raster counter advance: input side on beats, output side on results.
    always_comb begin
        in_col_d  = in_col_q;
        in_row_d  = in_row_q;
        out_col_d = out_col_q;
        out_row_d = out_row_q;
        if (beat) begin
            if (in_col_q == COL_LAST) begin
                in_col_d = '0;
                in_row_d = (in_row_q == ROW_LAST) ? '0 : in_row_q + RW'(1);
            end else begin
                in_col_d = in_col_q + CW'(1);
            end
        end
        if (produce) begin
            if (out_col_q == COL_LAST) begin
                out_col_d = '0;
                out_row_d = (out_row_q == ROW_LAST) ? '0 : out_row_q + RW'(1);
            end else begin
                out_col_d = out_col_q + CW'(1);
            end
        end
    end

    // FSM state and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FILL;
            in_col_q  <= '0;
            in_row_q  <= '0;
            out_col_q <= '0;
            out_row_q <= '0;
        end else begin
            state_q   <= state_d;
            in_col_q  <= in_col_d;
            in_row_q  <= in_row_d;
            out_col_q <= out_col_d;
            out_row_q <= out_row_d;
        end
    end

`ifdef MORPH_MODE_EN
    morph_mode_e mode_q;
    logic        frame_start;

    assign frame_start = beat && (state_q == FILL) && (in_col_q == '0) && (in_row_q == '0);

    // Capture the requested operation once per frame, on its first pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= MORPH_DILATE;
        end else if (frame_start) begin
            mode_q <= morph_mode_e'(mode);
        end
    end

    assign neutral = DATA_W'(morph_neutral(DATA_W, mode_q));
`else
    assign neutral = DATA_W'(morph_neutral(DATA_W, MORPH_DILATE));
`endif

    // Line 0 delays the stream by one line, line 1 by two lines.
    morph_line_buf #(
        .DATA_W (DATA_W),
        .IMG_W  (IMG_W)
    ) u_line0 (
        .clk    (clk),
        .en_i   (shift_en),
        .din_i  (pix_in),
        .dout_o (lb0_out)
    );

    morph_line_buf #(
        .DATA_W (DATA_W),
        .IMG_W  (IMG_W)
    ) u_line1 (
        .clk    (clk),
        .en_i   (shift_en),
        .din_i  (lb0_out),
        .dout_o (lb1_out)
    );

    // Column entering the window this cycle, oldest line first.
    always_comb begin
        new_col[0] = lb1_out;
        new_col[1] = lb0_out;
        new_col[2] = pix_in;
    end

    // Slide the window one column left on every shift.
    always_ff @(posedge clk) begin
        if (shift_en) begin
            for (int r = 0; r < WIN; r++) begin
                win_q[r][0] <= win_q[r][1];
                win_q[r][1] <= win_q[r][2];
                win_q[r][2] <= new_col[r];
            end
        end
    end

    // Taps of the window as it stands after this cycle's shift, so the
    // result registers on the same edge that accepts the completing pixel.
    always_comb begin
        for (int r = 0; r < WIN; r++) begin
            tap[r][0] = win_q[r][1];
            tap[r][1] = win_q[r][2];
            tap[r][2] = new_col[r];
        end
    end

    // Border masks relative to the centre pixel; these also hide line wrap,
    // stale line-buffer content and the flush dummies.
    always_comb begin
        row_ok = {out_row_q != ROW_LAST, 1'b1, out_row_q != '0};
        col_ok = {out_col_q != COL_LAST, 1'b1, out_col_q != '0};
    end

    // Compare tree over the nine masked taps.
    always_comb begin
        result = neutral;
        cand   = neutral;
        for (int r = 0; r < WIN; r++) begin
            for (int c = 0; c < WIN; c++) begin
                cand = (row_ok[r] && col_ok[c]) ? tap[r][c] : neutral;
`ifdef MORPH_MODE_EN
                if (mode_q == MORPH_ERODE) begin
                    if (cand < result) begin
                        result = cand;
                    end
                end else if (cand > result) begin
                    result = cand;
                end
`else
                if (cand > result) begin
                    result = cand;
                end
`endif
            end
        end
    end

    // Single output register stage after the compare tree.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= produce;
            if (produce) begin
                out_data_q <= result;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_morph_filter_3x3.sv
// Directed bench for morph_filter_3x3 on a 4x3 frame of 8-bit pixels.
// Erode cases are only exercised when MORPH_MODE_EN is defined.
module tb_morph_filter_3x3;

    localparam int DATA_W = 8;
    localparam int IMG_W  = 4;
    localparam int IMG_H  = 3;
    localparam int NPIX   = IMG_W * IMG_H;

    logic       clk = 1'b0;
    logic       rst;
`ifdef MORPH_MODE_EN
    logic       mode;
`endif
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic [7:0] out_data;

    int n_total = 0;
    int n_pass  = 0;

    logic [7:0] got [$];
    logic [7:0] img   [NPIX];
    logic [7:0] exp_t [NPIX];

    always #5 clk = ~clk;

    morph_filter_3x3 #(
        .DATA_W (DATA_W),
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H)
    ) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef MORPH_MODE_EN
        .mode      (mode),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    // Collect every result on the falling edge.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            got.push_back(out_data);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Offer one pixel and hold it until accepted; reports cycles spent waiting.
    task automatic push(input logic [7:0] p, output int waited);
        waited   = 0;
        in_valid = 1'b1;
        in_data  = p;
        while (in_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 50) begin
            n_total++;
            $error("FAIL push_timeout: waited %0d cycles for in_ready, required < 50", waited);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input int max_gap, output int first_wait);
        int w;
        first_wait = 0;
        for (int i = 0; i < NPIX; i++) begin
            if (max_gap > 0) begin
                repeat ($urandom_range(32'(max_gap), 0)) @(negedge clk);
            end
            push(img[i], w);
            if (i == 0) begin
                first_wait = w;
            end
        end
    endtask

    task automatic wait_results(input int n, input string tag);
        int guard;
        guard = 0;
        while (got.size() < n && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        repeat (8) @(negedge clk);
        #1;
        chk({tag, "_count"}, 32'(got.size()), 32'(n));
    endtask

    task automatic check_frame(input int base, input string tag);
        logic [7:0] obs;
        for (int i = 0; i < NPIX; i++) begin
            obs = (base + i < got.size()) ? got[base + i] : 8'hxx;
            chk($sformatf("%s_px%0d", tag, i), {24'h0, obs}, {24'h0, exp_t[i]});
        end
    endtask

    task automatic load_ramp();
        for (int i = 0; i < NPIX; i++) begin
            img[i] = 8'(i);
        end
    endtask

    task automatic load_corner();
        img     = '{default: 8'h10};
        img[0]  = 8'hC0;
        img[11] = 8'h33;
    endtask

    initial begin
        int w;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
`ifdef MORPH_MODE_EN
        mode     = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_in_ready",  {31'h0, in_ready},  32'h0);
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_out_data",  {24'h0, out_data},  32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", {31'h0, in_ready}, 32'h1);

        // Dilate impulse at (1,1).
        img    = '{default: 8'h00};
        img[5] = 8'h80;
        exp_t  = '{8'h80, 8'h80, 8'h80, 8'h00,
                   8'h80, 8'h80, 8'h80, 8'h00,
                   8'h80, 8'h80, 8'h80, 8'h00};
        got.delete();
        send_frame(0, w);
        wait_results(NPIX, "dil_imp");
        check_frame(0, "dil_imp");

`ifdef MORPH_MODE_EN
        // Erode hole at (1,1); corners must not be pulled low by the border.
        mode   = 1'b1;
        img    = '{default: 8'hFF};
        img[5] = 8'h00;
        exp_t  = '{8'h00, 8'h00, 8'h00, 8'hFF,
                   8'h00, 8'h00, 8'h00, 8'hFF,
                   8'h00, 8'h00, 8'h00, 8'hFF};
        got.delete();
        send_frame(0, w);
        wait_results(NPIX, "ero_imp");
        check_frame(0, "ero_imp");
        mode = 1'b0;
`endif

        // Constant frame: borders must leave the value untouched.
        img   = '{default: 8'h55};
        exp_t = '{default: 8'h55};
        got.delete();
        send_frame(0, w);
        wait_results(NPIX, "dil_const");
        check_frame(0, "dil_const");

`ifdef MORPH_MODE_EN
        mode = 1'b1;
        got.delete();
        send_frame(0, w);
        wait_results(NPIX, "ero_const");
        check_frame(0, "ero_const");
        mode = 1'b0;
`endif

        // Back-to-back frames; the second frame's first pixel is held through the flush.
        got.delete();
        load_ramp();
        send_frame(0, w);
        load_corner();
        send_frame(0, w);
        chk("flush_stall_cycles", 32'(w), 32'd5);
        wait_results(2 * NPIX, "b2b");
        exp_t = '{8'h05, 8'h06, 8'h07, 8'h07,
                  8'h09, 8'h0A, 8'h0B, 8'h0B,
                  8'h09, 8'h0A, 8'h0B, 8'h0B};
        check_frame(0, "b2b_ramp");
        exp_t = '{8'hC0, 8'hC0, 8'h10, 8'h10,
                  8'hC0, 8'hC0, 8'h33, 8'h33,
                  8'h10, 8'h10, 8'h33, 8'h33};
        check_frame(NPIX, "b2b_corner");

        // Random gaps with a mode request change mid-frame.
        load_ramp();
        got.delete();
        for (int i = 0; i < NPIX; i++) begin
`ifdef MORPH_MODE_EN
            if (i == 6) begin
                mode = 1'b1;
            end
`endif
            repeat ($urandom_range(3, 0)) @(negedge clk);
            push(img[i], w);
        end
        wait_results(NPIX, "gap_dil");
        exp_t = '{8'h05, 8'h06, 8'h07, 8'h07,
                  8'h09, 8'h0A, 8'h0B, 8'h0B,
                  8'h09, 8'h0A, 8'h0B, 8'h0B};
        check_frame(0, "gap_dil");

`ifdef MORPH_MODE_EN
        // The erode request now applies to the following frame.
        got.delete();
        send_frame(2, w);
        wait_results(NPIX, "gap_ero");
        exp_t = '{8'h00, 8'h00, 8'h01, 8'h02,
                  8'h00, 8'h00, 8'h01, 8'h02,
                  8'h04, 8'h04, 8'h05, 8'h06};
        check_frame(0, "gap_ero");
        mode = 1'b0;
`endif

        // Reset after pixel 7 of a frame, then a clean full frame.
        load_ramp();
        for (int i = 0; i < 8; i++) begin
            push(img[i], w);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("midrst_in_ready",  {31'h0, in_ready},  32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("after_rst_in_ready",  {31'h0, in_ready},  32'h1);
        chk("after_rst_out_valid", {31'h0, out_valid}, 32'h0);
        got.delete();
        load_corner();
        send_frame(0, w);
        wait_results(NPIX, "post_rst");
        exp_t = '{8'hC0, 8'hC0, 8'h10, 8'h10,
                  8'hC0, 8'hC0, 8'h33, 8'h33,
                  8'h10, 8'h10, 8'h33, 8'h33};
        check_frame(0, "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
